ram_req_ctrl: RTL

//  Request sequencer directly upstream of the 8x8 single-port RAM: sole driver of the RAM's we/addr/din.

---
 rtl/ram_req_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ram_req_ctrl.sv
// Burst request sequencer in front of a single-port RAM with registered read data.
// Streams write beats straight into the RAM and returns read beats on a backpressured port.
module ram_req_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // a producer holds its payload stable while valid is high and ready is low.

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ISSUE = 3'd2,
        RD_CAP   = 3'd3,
        RD_RSP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_last_q, rsp_last_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_last_d  = rsp_last_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    cnt_d   = cmd_len;
                    state_d = cmd_wr ? WR : RD_ISSUE;
                end
            end
            WR: begin
                if (wdata_valid) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - ADDR_W'(1);
                    end
                end
            end
            RD_ISSUE: begin
                state_d = RD_CAP;
            end
            RD_CAP: begin
                // RAM dout now reflects the address presented during RD_ISSUE
                rsp_data_d  = ram_dout;
                rsp_valid_d = 1'b1;
                rsp_last_d  = (cnt_q == '0);
                state_d     = RD_RSP;
            end
            RD_RSP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        cnt_d   = cnt_q - ADDR_W'(1);
                        state_d = RD_ISSUE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Write enable is gated by rst_n so a reset landing mid-burst cannot commit a beat.
    assign ram_we      = (state_q == WR) && wdata_valid && rst_n;
    assign ram_addr    = addr_q;
    assign ram_din     = wdata;
    assign cmd_ready   = (state_q == IDLE);
    assign wdata_ready = (state_q == WR);
    assign busy        = (state_q != IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_last    = rsp_last_q;
    assign rsp_data    = rsp_data_q;

endmodule
